// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and sizing helpers for serial arithmetic blocks
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Counter must be able to hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done operand and result bundle; ovf present with SERIAL_SUBTRACTOR_OVF_EN
interface serial_subtractor_if #(
  parameter int WIDTH = serial_arith_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  modport master (output start, a, b, borrow_in, input busy, done, diff, borrow_out, ovf);
  modport slave  (input start, a, b, borrow_in, output busy, done, diff, borrow_out, ovf);
`else
  modport master (output start, a, b, borrow_in, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, borrow_in, output busy, done, diff, borrow_out);
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - combinational 1-bit full subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - borrow_in, LSB first; optional ovf via SERIAL_SUBTRACTOR_OVF_EN
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   res;
  logic               br;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               shift;
  logic               latch;
  logic               last_bit;
  logic               d_bit;
  logic               br_next;
  logic               done_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_q;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  full_subtractor u_cell (
    .a    (opa[0]),
    .b    (opb[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        latch      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      done_q <= latch;
      if (load) begin
        opa <= bus.a;
        opb <= bus.b;
        br  <= bus.borrow_in;
        cnt <= '0;
      end
      if (shift) begin
        opa <= opa >> 1;
        opb <= opb >> 1;
        res <= {d_bit, res[WIDTH-1:1]};
        br  <= br_next;
        if (cnt != CNT_W'(WIDTH)) cnt <= cnt + CNT_W'(1);
      end
      // Outputs only change here, so they never show a partial result.
      if (latch) begin
        diff_q   <= res;
        borrow_q <= br;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic br_msb;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_msb <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (shift && last_bit) br_msb <= br;
      if (latch) ovf_q <= br_msb ^ br;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy       = (state == SHIFT) || (state == DONE);
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule
